// File: rtl/c_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : c_arbiter_pkg
// Purpose  : Shared sizing constants and the clause type for the clause
//            arbiter. The clause source and the downstream clause queues
//            import the same package.
// Contents : OUTPUT_CNT, CLAUSE_WIDTH, ELEMENT_CNT, ELEMENT_BIT_CNT,
//            CNT_BIT, PTR_W, clause_t, sat_count()
// Revision : 1.0 - initial release
// ============================================================================
package c_arbiter_pkg;

  localparam int OUTPUT_CNT      = 4;
  localparam int CLAUSE_WIDTH    = 3;
  localparam int ELEMENT_CNT     = 16;
  localparam int ELEMENT_BIT_CNT = $clog2(ELEMENT_CNT) + 1;  // sign + index
  localparam int CNT_BIT         = $clog2(OUTPUT_CNT) + 1;
  localparam int PTR_W           = $clog2(OUTPUT_CNT);

  typedef logic [CLAUSE_WIDTH*ELEMENT_BIT_CNT-1:0] clause_t;

  // Clamp a bundle count to the number of physical slots.
  function automatic logic [CNT_BIT-1:0] sat_count(input logic [CNT_BIT-1:0] cnt);
    if (cnt > CNT_BIT'(OUTPUT_CNT)) begin
      return CNT_BIT'(OUTPUT_CNT);
    end
    return cnt;
  endfunction

endpackage : c_arbiter_pkg
`default_nettype wire

// File: rtl/c_arbiter_rotate.sv
`default_nettype none
// ============================================================================
// Module   : c_arbiter_rotate
// Purpose  : Assigns a bundle slot index to every queue. The full mask is
//            rotated so the scan start (ptr_i) lands at position 0, an
//            exclusive prefix count of free queues is taken, and the counts
//            are rotated back to queue order.
// Ports    : full_i  - per-queue full flags
//            ptr_i   - scan start queue
//            free_o  - per-queue eligibility (not full)
//            slot_o  - per-queue bundle slot it would receive
// Revision : 1.0 - initial release
// ============================================================================
module c_arbiter_rotate
  import c_arbiter_pkg::*;
(
  input  logic [OUTPUT_CNT-1:0]              full_i,
  input  logic [PTR_W-1:0]                   ptr_i,
  output logic [OUTPUT_CNT-1:0]              free_o,
  output logic [OUTPUT_CNT-1:0][CNT_BIT-1:0] slot_o
);

  logic [OUTPUT_CNT-1:0]              rot_free;
  logic [OUTPUT_CNT-1:0][CNT_BIT-1:0] rot_slot;
  logic [CNT_BIT-1:0]                 run_cnt;

  assign free_o = ~full_i;

  always_comb begin
    rot_free = '0;
    rot_slot = '0;
    slot_o   = '0;
    run_cnt  = '0;
    // Position j of the rotated view is queue (ptr + j) mod OUTPUT_CNT.
    for (int j = 0; j < OUTPUT_CNT; j++) begin
      rot_free[j] = ~full_i[(int'(ptr_i) + j) % OUTPUT_CNT];
    end
    // Exclusive prefix: number of free queues scanned before position j.
    for (int j = 0; j < OUTPUT_CNT; j++) begin
      rot_slot[j] = run_cnt;
      run_cnt     = run_cnt + {{(CNT_BIT-1){1'b0}}, rot_free[j]};
    end
    for (int q = 0; q < OUTPUT_CNT; q++) begin
      slot_o[q] = rot_slot[(q + OUTPUT_CNT - int'(ptr_i)) % OUTPUT_CNT];
    end
  end

endmodule : c_arbiter_rotate
`default_nettype wire

// File: rtl/c_arbiter_v3.sv
`default_nettype none
// ============================================================================
// Module   : c_arbiter_v3
// Purpose  : Clause distribution arbiter. Steers an in-order bundle of up to
//            OUTPUT_CNT clauses onto the non-full downstream queues, starting
//            the scan at a round-robin pointer. Outputs are combinational.
// Ports    : clock, reset       - clock, async active-high reset
//            clause_in          - bundle, slot 0 oldest
//            clause_cnt_in      - valid slots (saturates at OUTPUT_CNT)
//            full_in            - per-queue full flags
//            clause_out         - clause per queue (0 when not granted)
//            clause_accept_out  - number of slots consumed
//            grant_out          - per-queue write enable
// Config   : C_ARBITER_RR_EN defined   -> round-robin start pointer
//            C_ARBITER_RR_EN undefined -> fixed priority from queue 0
// Revision : 1.0 - initial release
// ============================================================================
module c_arbiter_v3
  import c_arbiter_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  clause_t [OUTPUT_CNT-1:0]       clause_in,
  input  logic    [CNT_BIT-1:0]          clause_cnt_in,
  input  logic    [OUTPUT_CNT-1:0]       full_in,
  output clause_t [OUTPUT_CNT-1:0]       clause_out,
  output logic    [CNT_BIT-1:0]          clause_accept_out,
  output logic    [OUTPUT_CNT-1:0]       grant_out
);

  logic [PTR_W-1:0]                   ptr;
  logic [CNT_BIT-1:0]                 n_sat;
  logic [OUTPUT_CNT-1:0]              free;
  logic [OUTPUT_CNT-1:0][CNT_BIT-1:0] slot;
  logic [OUTPUT_CNT-1:0]              grant_c;
  clause_t [OUTPUT_CNT-1:0]           clause_c;
  logic [CNT_BIT-1:0]                 accept_c;

  assign n_sat = sat_count(clause_cnt_in);

  c_arbiter_rotate u_rotate (
    .full_i (full_in),
    .ptr_i  (ptr),
    .free_o (free),
    .slot_o (slot)
  );

  // A free queue is granted when its slot index falls inside the bundle.
  // Because slot indices are consecutive over free queues, the granted
  // queues always take slots 0..accept-1 in order.
  always_comb begin
    grant_c  = '0;
    clause_c = '0;
    accept_c = '0;
    for (int q = 0; q < OUTPUT_CNT; q++) begin
      if (free[q] && (slot[q] < n_sat)) begin
        grant_c[q]  = 1'b1;
        clause_c[q] = clause_in[slot[q][PTR_W-1:0]];
        accept_c    = accept_c + CNT_BIT'(1);
      end
    end
  end

`ifdef C_ARBITER_RR_EN
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // The last granted queue in scan order carries slot accept-1; the next
  // scan starts just after it. With no grant the pointer holds.
  always_comb begin
    ptr_d = ptr_q;
    for (int q = 0; q < OUTPUT_CNT; q++) begin
      if (grant_c[q] && (slot[q] == (accept_c - CNT_BIT'(1)))) begin
        ptr_d = PTR_W'((q + 1) % OUTPUT_CNT);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // Outputs are forced quiet for as long as reset is asserted.
  assign grant_out         = reset ? '0 : grant_c;
  assign clause_out        = reset ? '0 : clause_c;
  assign clause_accept_out = reset ? '0 : accept_c;

endmodule : c_arbiter_v3
`default_nettype wire

// File: tb/tb_c_arbiter_v3.sv
`default_nettype none
// ============================================================================
// Module   : tb_c_arbiter_v3
// Purpose  : Directed self-checking bench for c_arbiter_v3. Expected values
//            are hand-derived for both the round-robin build
//            (C_ARBITER_RR_EN) and the fixed-priority build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c_arbiter_v3;
  import c_arbiter_pkg::*;

  logic                     clock;
  logic                     reset;
  clause_t [OUTPUT_CNT-1:0] clause_in;
  logic    [CNT_BIT-1:0]    clause_cnt_in;
  logic    [OUTPUT_CNT-1:0] full_in;
  clause_t [OUTPUT_CNT-1:0] clause_out;
  logic    [CNT_BIT-1:0]    clause_accept_out;
  logic    [OUTPUT_CNT-1:0] grant_out;

  int tests_run;
  int tests_failed;

  c_arbiter_v3 dut (
    .clock             (clock),
    .reset             (reset),
    .clause_in         (clause_in),
    .clause_cnt_in     (clause_cnt_in),
    .full_in           (full_in),
    .clause_out        (clause_out),
    .clause_accept_out (clause_accept_out),
    .grant_out         (grant_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slot labels A..D map to distinct clause values.
  function automatic clause_t lbl(input int k);
    return clause_t'(32'h0A01 + 32'h0101 * k);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // map holds the expected slot per queue {q3,q2,q1,q0}; 7 = no clause.
  typedef struct {
    logic [2:0]  cnt;
    logic [3:0]  full;
    logic [3:0]  grant;
    logic [2:0]  acc;
    logic [11:0] map;
  } vec_t;

  vec_t vecs[13];

  task automatic check_outputs(input string name, input logic [3:0] g,
                               input logic [2:0] a, input logic [11:0] m);
    logic [2:0] s;
    check($sformatf("%s grant", name), 64'(grant_out), 64'(g));
    check($sformatf("%s accept", name), 64'(clause_accept_out), 64'(a));
    for (int q = 0; q < OUTPUT_CNT; q++) begin
      s = m[q*3 +: 3];
      check($sformatf("%s q%0d", name, q), 64'(clause_out[q]),
            (s == 3'd7) ? 64'd0 : 64'(lbl(int'(s))));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int k = 0; k < OUTPUT_CNT; k++) clause_in[k] = lbl(k);

`ifdef C_ARBITER_RR_EN
    vecs[0]  = '{3'd4, 4'b1001, 4'b0110, 3'd2, {3'd7, 3'd1, 3'd0, 3'd7}}; // ptr0->3
    vecs[1]  = '{3'd4, 4'b0000, 4'b1111, 3'd4, {3'd0, 3'd3, 3'd2, 3'd1}}; // ptr3->3
    vecs[2]  = '{3'd2, 4'b0000, 4'b1001, 3'd2, {3'd0, 3'd7, 3'd7, 3'd1}}; // ptr3->1
    vecs[3]  = '{3'd1, 4'b0010, 4'b0100, 3'd1, {3'd7, 3'd0, 3'd7, 3'd7}}; // ptr1->3
    vecs[4]  = '{3'd1, 4'b0010, 4'b1000, 3'd1, {3'd0, 3'd7, 3'd7, 3'd7}}; // ptr3->0
    vecs[5]  = '{3'd1, 4'b0010, 4'b0001, 3'd1, {3'd7, 3'd7, 3'd7, 3'd0}}; // ptr0->1
    vecs[6]  = '{3'd4, 4'b1111, 4'b0000, 3'd0, {3'd7, 3'd7, 3'd7, 3'd7}}; // hold 1
    vecs[7]  = '{3'd0, 4'b0000, 4'b0000, 3'd0, {3'd7, 3'd7, 3'd7, 3'd7}}; // hold 1
    vecs[8]  = '{3'd1, 4'b0000, 4'b0010, 3'd1, {3'd7, 3'd7, 3'd0, 3'd7}}; // ptr1->2
    vecs[9]  = '{3'd2, 4'b0000, 4'b1100, 3'd2, {3'd1, 3'd0, 3'd7, 3'd7}}; // ptr2->0
    vecs[10] = '{3'd7, 4'b0000, 4'b1111, 3'd4, {3'd3, 3'd2, 3'd1, 3'd0}}; // ptr0->0
    vecs[11] = '{3'd4, 4'b0101, 4'b1010, 3'd2, {3'd1, 3'd7, 3'd0, 3'd7}}; // ptr0->0
    vecs[12] = '{3'd1, 4'b0000, 4'b0001, 3'd1, {3'd7, 3'd7, 3'd7, 3'd0}}; // ptr0->1
`else
    vecs[0]  = '{3'd4, 4'b1001, 4'b0110, 3'd2, {3'd7, 3'd1, 3'd0, 3'd7}};
    vecs[1]  = '{3'd4, 4'b1001, 4'b0110, 3'd2, {3'd7, 3'd1, 3'd0, 3'd7}};
    vecs[2]  = '{3'd2, 4'b0000, 4'b0011, 3'd2, {3'd7, 3'd7, 3'd1, 3'd0}};
    vecs[3]  = '{3'd1, 4'b0010, 4'b0001, 3'd1, {3'd7, 3'd7, 3'd7, 3'd0}};
    vecs[4]  = '{3'd1, 4'b0010, 4'b0001, 3'd1, {3'd7, 3'd7, 3'd7, 3'd0}};
    vecs[5]  = '{3'd4, 4'b0000, 4'b1111, 3'd4, {3'd3, 3'd2, 3'd1, 3'd0}};
    vecs[6]  = '{3'd4, 4'b1111, 4'b0000, 3'd0, {3'd7, 3'd7, 3'd7, 3'd7}};
    vecs[7]  = '{3'd0, 4'b0000, 4'b0000, 3'd0, {3'd7, 3'd7, 3'd7, 3'd7}};
    vecs[8]  = '{3'd1, 4'b0000, 4'b0001, 3'd1, {3'd7, 3'd7, 3'd7, 3'd0}};
    vecs[9]  = '{3'd3, 4'b1000, 4'b0111, 3'd3, {3'd7, 3'd2, 3'd1, 3'd0}};
    vecs[10] = '{3'd7, 4'b0000, 4'b1111, 3'd4, {3'd3, 3'd2, 3'd1, 3'd0}};
    vecs[11] = '{3'd4, 4'b0101, 4'b1010, 3'd2, {3'd1, 3'd7, 3'd0, 3'd7}};
    vecs[12] = '{3'd1, 4'b0000, 4'b0001, 3'd1, {3'd7, 3'd7, 3'd7, 3'd0}};
`endif

    // Reset state: outputs quiet even with a full bundle and free queues.
    reset         = 1'b1;
    clause_cnt_in = 3'd4;
    full_in       = 4'b0000;
    #1;
    check_outputs("reset", 4'b0000, 3'd0, {4{3'd7}});
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (i != 0) @(negedge clock);
      clause_cnt_in = vecs[i].cnt;
      full_in       = vecs[i].full;
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].grant, vecs[i].acc, vecs[i].map);
    end

    // Mid-stream reset: outputs drop at once and the pointer clears.
    @(negedge clock);
    clause_cnt_in = 3'd4;
    full_in       = 4'b0000;
    reset         = 1'b1;
    #1;
    check_outputs("midrst", 4'b0000, 3'd0, {4{3'd7}});
    @(posedge clock);
    @(negedge clock);
    reset         = 1'b0;
    clause_cnt_in = 3'd1;
    #1;
    check_outputs("postrst", 4'b0001, 3'd1, {3'd7, 3'd7, 3'd7, 3'd0});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_c_arbiter_v3
`default_nettype wire

// File: doc/c_arbiter_v3.md
Name: c_arbiter_v3

Overview:
- Clause distribution arbiter. Each cycle it receives a bundle of up to OUTPUT_CNT clauses from the clause source.
- It steers those clauses, in order, onto the non-full downstream clause queues, using a registered round-robin start pointer.
- It reports which queues receive a clause and how many input clauses were consumed. The source drops that many clauses from the front of its bundle.

Parameters:
- OUTPUT_CNT, 4: number of downstream queues, which is also the maximum number of clauses per bundle.
- CLAUSE_WIDTH, 3: literals per clause.
- ELEMENT_CNT, 16: number of variables supported.
- ELEMENT_BIT_CNT, $clog2(ELEMENT_CNT)+1 = 5: bits per literal (sign plus index).
- CNT_BIT, $clog2(OUTPUT_CNT)+1 = 3: width of the count fields.

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- clause_in, in, [OUTPUT_CNT][CLAUSE_WIDTH*ELEMENT_BIT_CNT]: the bundle; slot 0 is the oldest clause.
- clause_cnt_in, in, CNT_BIT: number of valid slots, counted from slot 0.
- full_in, in, OUTPUT_CNT: bit q set means queue q cannot accept a clause this cycle.
- clause_out, out, [OUTPUT_CNT][CLAUSE_WIDTH*ELEMENT_BIT_CNT]: entry q is the clause driven to queue q.
- clause_accept_out, out, CNT_BIT: number of input slots consumed this cycle.
- grant_out, out, OUTPUT_CNT: bit q is the write enable for queue q.

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-high (reset).
- State is a single pointer ptr of width $clog2(OUTPUT_CNT). It is cleared to 0 asynchronously on reset.
- Outputs are combinational from the inputs and ptr, with zero latency; results are valid within the same cycle.
- While reset is high, grant_out=0, clause_accept_out=0 and clause_out=0.
- Effective count n = min(clause_cnt_in, OUTPUT_CNT). Values above OUTPUT_CNT saturate.
- Eligibility:
  - Queue q is eligible when full_in[q]==0.
  - Eligible queues are scanned in order ptr, ptr+1, ..., wrapping modulo OUTPUT_CNT.
  - The k-th eligible queue in scan order (k=0,1,...) receives clause_in[k] while k<n.
- Outputs from the scan:
  - grant_out[q]=1 for exactly those receiving queues.
  - clause_out[q]=clause_in[k] for granted queues; clause_out[q]=0 for non-granted queues.
  - clause_accept_out = min(n, popcount(~full_in)) = popcount(grant_out).
- Clauses are never reordered or duplicated. The accepted clauses are always slots 0..clause_accept_out-1.
- Pointer update at the rising edge:
  - If grant_out!=0, ptr <= (index of the last granted queue in scan order + 1) mod OUTPUT_CNT.
  - Otherwise ptr holds.
- Boundary cases:
  - All queues full, or n=0: no grants, accept=0, ptr holds.
  - Fewer free queues than clauses: only the leading clauses are accepted.
  - Full queues are skipped with no slot consumed.
- full_in is sampled only combinationally; a queue going full mid-bundle is simply skipped that cycle.

Optional Feature:
- Macro C_ARBITER_RR_EN.
- Defined: round-robin pointer as above.
- Undefined: fixed priority. ptr is tied to 0, the scan always starts at queue 0, and the pointer register is not built. All other behaviour is identical.

Decomposition:
- Package c_arbiter_pkg holds OUTPUT_CNT, CLAUSE_WIDTH, ELEMENT_CNT, ELEMENT_BIT_CNT, CNT_BIT and a clause_t typedef (logic [CLAUSE_WIDTH*ELEMENT_BIT_CNT-1:0]). The same package is shared with the clause source and the queues.
- One sub-module, c_arbiter_rotate: rotates full_in by ptr, computes prefix counts of eligible queues (slot index per queue), and un-rotates.
- The top level holds ptr, the saturation of n and the output muxing.

Test Plan (C_ARBITER_RR_EN defined; clauses are labelled A..D for slots 0..3):
- After reset, ptr=0. Cnt=4, full=1001 → grant=0110, q1=A, q2=B, q0=q3=0, accept=2; next ptr=3.
- Then cnt=4, full=0000 → grant=1111, q3=A, q0=B, q1=C, q2=D, accept=4; next ptr=3.
- Then cnt=2, full=0000 → grant=1001, q3=A, q0=B, accept=2; next ptr=1.
- Cnt=1, full=0010 with ptr=1 → q2=A, grant=0100, accept=1, ptr=3. Repeat with cnt=1: q3, then q0, with ptr advancing each cycle.
- Full=1111 with cnt=4 → grant=0, accept=0, clause_out=0, ptr unchanged. Cnt=0 with full=0000 gives the same result.
- Cnt=7 (saturate), full=0000, ptr=0 → accept=4, grant=1111. Asserting reset mid-stream zeroes the outputs immediately and clears ptr. With the macro undefined, the first scenario is repeated twice and gives grant=0110 both times.
